// File: rtl/mem_pkg.sv
// Shared types and constants for the parameterised data memory: FSM states,
// access-size encodings and byte-lane width.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   localparam int LANE_W = 8;

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane helper: builds the word to write back and the value to return
// for byte or word accesses (little-endian, lane 0 = bits [7:0]).
module dm_lane_merge
   import mem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  lane,
   input  logic        size,
   output logic [31:0] merged,
   output logic [31:0] rd_val
);

   // NOTE: every output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      merged = wdata;
      rd_val = old_word;
      if (size == SIZE_BYTE) begin
         merged = old_word;
         merged[lane*LANE_W +: LANE_W] = wdata[LANE_W-1:0];
         rd_val = {{(32-LANE_W){1'b0}}, old_word[lane*LANE_W +: LANE_W]};
      end
   end

endmodule

// File: rtl/param_data_memory.sv
// Single-port 32-bit data memory with byte/word access, a programmable
// access latency and a one-cycle ready/err completion handshake.
module param_data_memory
   import mem_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic        size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        we_q, size_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem [DEPTH];

   logic             acc_we, acc_size;
   logic [31:0]      acc_addr, acc_wdata;
   logic [IDX_W-1:0] idx;
   logic             out_of_range, misaligned, acc_err, commit;
   logic [31:0]      merged, rd_val;

   // With zero latency the access happens on the accepting edge itself, so
   // the live inputs are used instead of the latched copy.
   always_comb begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state == IDLE) begin
         acc_we    = we;
         acc_size  = size;
         acc_addr  = addr;
         acc_wdata = wdata;
      end
   end

   assign idx          = acc_addr[IDX_W+1:2];
   assign out_of_range = |acc_addr[31:IDX_W+2];
   assign misaligned   = (acc_size == SIZE_WORD) && (acc_addr[1:0] != 2'b00);
   assign acc_err      = out_of_range || misaligned;
   assign commit       = (state != DONE) && (state_nxt == DONE);

   dm_lane_merge u_lane_merge (
      .old_word (mem[idx]),
      .wdata    (acc_wdata),
      .lane     (acc_addr[1:0]),
      .size     (acc_size),
      .merged   (merged),
      .rd_val   (rd_val)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = (LATENCY == 0) ? DONE : WAIT;
         WAIT:    if (cnt <= 4'd1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: the array is cleared on reset because a zeroed memory is part of the
   // reset state; this forces a flop-based implementation rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         size_q  <= SIZE_BYTE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (state == IDLE && req) begin
            we_q    <= we;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 4'(LATENCY);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || acc_we) ? 32'd0 : rd_val;
            if (acc_we && !acc_err) mem[idx] <= merged;
         end
      end
   end

   assign busy  = (state != IDLE);
   assign ready = (state == DONE);
   assign rdata = ready ? rdata_q : 32'd0;
   assign err   = ready ? err_q : 1'b0;

endmodule

// File: tb/tb_param_data_memory.sv
// Bench: three memories (latency 1, 3, 0) driven by shared stimulus and
// compared against an array-based reference model of the memory contents.
module tb_param_data_memory;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic        size = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;

   logic        busy_l1, ready_l1, err_l1;
   logic        busy_l3, ready_l3, err_l3;
   logic        busy_l0, ready_l0, err_l0;
   logic [31:0] rdata_l1, rdata_l3, rdata_l0;

   int errors = 0;
   int checks = 0;
   int txn_no = 0;
   logic [31:0] model [64];

   always #5 clk = ~clk;

   param_data_memory #(.DEPTH(64), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
      .busy(busy_l1), .ready(ready_l1), .rdata(rdata_l1), .err(err_l1));

   param_data_memory #(.DEPTH(64), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
      .busy(busy_l3), .ready(ready_l3), .rdata(rdata_l3), .err(err_l3));

   param_data_memory #(.DEPTH(64), .LATENCY(0)) u_l0 (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
      .busy(busy_l0), .ready(ready_l0), .rdata(rdata_l0), .err(err_l0));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      case (d)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic void peek(input int d, output logic b, output logic r,
                                output logic e, output logic [31:0] rd);
      case (d)
         0:       begin b = busy_l1; r = ready_l1; e = err_l1; rd = rdata_l1; end
         1:       begin b = busy_l3; r = ready_l3; e = err_l3; rd = rdata_l3; end
         default: begin b = busy_l0; r = ready_l0; e = err_l0; rd = rdata_l0; end
      endcase
   endfunction

   // Reference model: word array updated by plain masking and shifting.
   task automatic model_access(input logic w, input logic s, input logic [31:0] a,
                               input logic [31:0] wd, output logic [31:0] exp_rd,
                               output logic exp_err);
      int unsigned idx;
      int unsigned lane;
      logic [31:0] mask;
      idx     = a >> 2;
      lane    = a % 4;
      mask    = 32'hFF << (8 * lane);
      exp_err = (idx >= 64) || (s && lane != 0);
      exp_rd  = 32'd0;
      if (!exp_err) begin
         if (w) begin
            if (s) model[idx] = wd;
            else   model[idx] = (model[idx] & ~mask) | ((wd & 32'hFF) << (8 * lane));
         end else begin
            exp_rd = s ? model[idx] : ((model[idx] & mask) >> (8 * lane));
         end
      end
   endtask

   // Called in the low phase of clk; returns in the low phase 18 cycles later.
   task automatic do_txn(input logic w, input logic s, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd1, output logic e1);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          rdy_n [3];
      int          pulses [3];
      int          bad_idle [3];
      logic [31:0] got_rd [3];
      logic        got_err [3];
      logic        b, r, e;
      logic [31:0] rdv;
      model_access(w, s, a, wd, exp_rd, exp_err);
      for (int d = 0; d < 3; d++) begin
         rdy_n[d] = -1; pulses[d] = 0; bad_idle[d] = 0; got_rd[d] = '0; got_err[d] = 1'b0;
      end
      req = 1'b1; we = w; size = s; addr = a; wdata = wd;
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         req = 1'b0;
         for (int d = 0; d < 3; d++) begin
            peek(d, b, r, e, rdv);
            if (r) begin
               pulses[d]++;
               if (rdy_n[d] < 0) rdy_n[d] = n;
               got_rd[d]  = rdv;
               got_err[d] = e;
            end else if (rdv != 32'd0 || e) begin
               bad_idle[d]++;
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         peek(d, b, r, e, rdv);
         check($sformatf("t%0d_L%0d_ready_cycle", txn_no, lat_of(d)), rdy_n[d], 1 + lat_of(d));
         check($sformatf("t%0d_L%0d_ready_pulses", txn_no, lat_of(d)), pulses[d], 1);
         check($sformatf("t%0d_L%0d_rdata", txn_no, lat_of(d)), got_rd[d], exp_rd);
         check($sformatf("t%0d_L%0d_err", txn_no, lat_of(d)), got_err[d], exp_err);
         check($sformatf("t%0d_L%0d_idle_outputs", txn_no, lat_of(d)), bad_idle[d], 0);
         check($sformatf("t%0d_L%0d_busy_end", txn_no, lat_of(d)), b, 0);
      end
      rd1 = got_rd[0];
      e1  = got_err[0];
      txn_no++;
   endtask

   // req held high: acceptances every LATENCY+2 cycles, busy LATENCY+1 cycles each.
   task automatic stream_phase();
      int   nrise [3];
      int   nrun [3];
      int   run [3];
      logic prevb [3];
      int   rise_at [3][8];
      int   runs [3][8];
      logic b, r, e;
      logic [31:0] rdv;
      for (int d = 0; d < 3; d++) begin
         nrise[d] = 0; nrun[d] = 0; run[d] = 0; prevb[d] = 1'b0;
      end
      req = 1'b1; we = 1'b0; size = 1'b1; addr = 32'h10; wdata = '0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            peek(d, b, r, e, rdv);
            if (b && !prevb[d] && nrise[d] < 8) begin
               rise_at[d][nrise[d]] = n;
               nrise[d]++;
            end
            if (!b && prevb[d] && nrun[d] < 8) begin
               runs[d][nrun[d]] = run[d];
               nrun[d]++;
            end
            if (b) run[d]++;
            else   run[d] = 0;
            prevb[d] = b;
         end
      end
      req = 1'b0;
      repeat (20) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("stream_L%0d_enough_accepts", lat_of(d)), 32'(nrise[d] >= 3), 1);
         if (nrise[d] > 0)
            check($sformatf("stream_L%0d_first_accept", lat_of(d)), rise_at[d][0], 1);
         for (int i = 1; i < nrise[d]; i++)
            check($sformatf("stream_L%0d_spacing%0d", lat_of(d), i),
                  rise_at[d][i] - rise_at[d][i-1], lat_of(d) + 2);
         check($sformatf("stream_L%0d_enough_runs", lat_of(d)), 32'(nrun[d] >= 2), 1);
         for (int i = 0; i < nrun[d]; i++)
            check($sformatf("stream_L%0d_busy_len%0d", lat_of(d), i), runs[d][i], lat_of(d) + 1);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      logic        b, r;
      logic [31:0] rdv;
      int          abort_pulses [2];
      int          sel;
      logic        rw, rs;
      logic [31:0] ra;

      for (int i = 0; i < 64; i++) model[i] = '0;

      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         peek(d, b, r, e, rdv);
         check($sformatf("reset_L%0d_busy", lat_of(d)), b, 0);
         check($sformatf("reset_L%0d_ready", lat_of(d)), r, 0);
         check($sformatf("reset_L%0d_err", lat_of(d)), e, 0);
         check($sformatf("reset_L%0d_rdata", lat_of(d)), rdv, 0);
      end

      // Accepted on the very first edge with rst high.
      rst = 1'b1;
      do_txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, rd, e);
      do_txn(1'b0, 1'b1, 32'h10, 32'h0, rd, e);
      check("word_read_back", rd, 32'hDEADBEEF);
      check("word_read_err", e, 0);

      do_txn(1'b1, 1'b1, 32'h10, 32'h11223344, rd, e);
      do_txn(1'b1, 1'b0, 32'h11, 32'h555555AA, rd, e);
      do_txn(1'b0, 1'b1, 32'h10, 32'h0, rd, e);
      check("byte_merge_word", rd, 32'h1122AA44);
      do_txn(1'b0, 1'b0, 32'h13, 32'h0, rd, e);
      check("byte_read_lane3", rd, 32'h00000011);

      do_txn(1'b1, 1'b1, 32'h04, 32'h5555AAAA, rd, e);
      do_txn(1'b0, 1'b1, 32'h100, 32'h0, rd, e);
      check("oor_read_err", e, 1);
      check("oor_read_rdata", rd, 0);
      do_txn(1'b1, 1'b1, 32'h06, 32'hFFFFFFFF, rd, e);
      check("misaligned_write_err", e, 1);
      do_txn(1'b1, 1'b1, 32'h100, 32'h12345678, rd, e);
      do_txn(1'b0, 1'b1, 32'h04, 32'h0, rd, e);
      check("misaligned_no_modify", rd, 32'h5555AAAA);
      do_txn(1'b0, 1'b1, 32'h00, 32'h0, rd, e);
      check("oor_no_wrap", rd, 32'h0);

      stream_phase();

      for (int t = 0; t < 50; t++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)      ra = 32'($urandom_range(0, 255));
         else if (sel < 9) ra = 32'($urandom_range(256, 300));
         else              ra = $urandom;
         rw = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         do_txn(rw, rs, ra, $urandom, rd, e);
      end

      // Write accepted, then reset one cycle later aborts it.
      abort_pulses[0] = 0;
      abort_pulses[1] = 0;
      req = 1'b1; we = 1'b1; size = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (n == 0) begin
            req = 1'b0;
            rst = 1'b0;
         end
         if (n == 1) begin
            rst = 1'b1;
            check("abort_L3_busy_after_reset", busy_l3, 0);
         end
         if (ready_l1) abort_pulses[0]++;
         if (ready_l3) abort_pulses[1]++;
      end
      check("abort_L1_ready_pulses", abort_pulses[0], 0);
      check("abort_L3_ready_pulses", abort_pulses[1], 0);
      for (int i = 0; i < 64; i++) model[i] = '0;
      do_txn(1'b0, 1'b1, 32'h20, 32'h0, rd, e);
      check("abort_read_0x20", rd, 32'h0);
      do_txn(1'b0, 1'b1, 32'h10, 32'h0, rd, e);
      check("reset_cleared_0x10", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit words; power of two, 4..4096.
REQ-002 SHALL have parameter LATENCY, default 1: wait cycles between acceptance and data access; range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low (sampled only on rising clk).
REQ-005 SHALL have port req  input  1  access request; sampled in IDLE only.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port size  input  1  0 = byte, 1 = word.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  write data; for byte writes, bits [7:0] are used.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  32  read result; valid while ready is high.
REQ-013 SHALL have port err  output  1  error flag; valid while ready is high.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-015 SHALL accept a request in IDLE when req is high.
- Acceptance latches we, size, addr and wdata.
- Acceptance loads the wait counter with LATENCY.
- Next state is WAIT, or DONE if LATENCY = 0.
REQ-016 In WAIT, SHALL decrement the counter each cycle; on the cycle it reaches 0, SHALL go to DONE.
- A request accepted in cycle T SHALL have ready high in exactly cycle T+1+LATENCY.
REQ-017 The memory access (read capture or write commit) SHALL occur on the clock edge that enters DONE.
REQ-018 In DONE, SHALL hold ready high for one cycle, then return to IDLE.
- req is ignored in WAIT and DONE; there is no queuing.
- Minimum spacing between acceptances is LATENCY+2 cycles.
REQ-019 Word index SHALL be addr >> 2. The access is out of range when the index is >= DEPTH.
REQ-020 A word access with addr[1:0] != 0 SHALL be misaligned.
REQ-021 On an out-of-range or misaligned access:
- err = 1 with ready.
- rdata = 0.
- No memory word is modified.
REQ-022 Word read: rdata = mem[index].
REQ-023 Byte read: rdata = zero-extended byte lane addr[1:0], little-endian; lane 0 = bits [7:0].
REQ-024 Word write: mem[index] = wdata. Byte write SHALL replace only lane addr[1:0] with wdata[7:0].
REQ-025 Outside the ready cycle, SHALL hold ready = 0, err = 0 and rdata = 0.
REQ-026 For writes, rdata SHALL be 0 in the ready cycle.

Reset
REQ-027 While rst = 0 at a rising edge, SHALL apply reset:
- state = IDLE and counter = 0;
- busy = 0, ready = 0, err = 0, rdata = 0;
- all DEPTH words cleared to 0.
REQ-028 Reset during WAIT or DONE SHALL abort the transaction: no write commit and no ready pulse.
REQ-029 The first acceptance SHALL be possible in the first cycle with rst = 1.

Structure
REQ-030 A shared package mem_pkg SHALL hold:
- the FSM state type (IDLE/WAIT/DONE);
- the size encodings SIZE_BYTE = 0 and SIZE_WORD = 1;
- the lane-width constant (8).
REQ-031 Byte-lane extraction and merge SHALL live in one combinational sub-module, dm_lane_merge.
- Inputs: old word, wdata, lane, size.
- Outputs: merged word and extracted read value.
REQ-032 The wait counter SHALL be 4 bits wide, independent of LATENCY.

Verification
REQ-033 With LATENCY=1: word write 0xDEADBEEF to addr 0x10, then word read of 0x10.
- Required: ready in cycle T+2 after each acceptance.
- Required: rdata = 0xDEADBEEF, err = 0.
REQ-034 Byte write 0xAA to addr 0x11 over word 0x11223344, then word read of 0x10.
- Required: 0x1122AA44.
- Required: byte read of 0x13 returns 0x00000011.
REQ-035 With DEPTH=64: word read of addr 0x100 (index 64), and word write to addr 0x06.
- Required for each: err = 1, rdata = 0.
- Required: the memory is unchanged.
REQ-036 With LATENCY=3: req held high continuously.
- Required: acceptances exactly 5 cycles apart.
- Required: busy high for 4 cycles per transaction.
REQ-037 Write to 0x20 accepted with LATENCY=3; rst = 0 one cycle later; then word read of 0x20.
- Required: no ready pulse for the aborted write.
- Required: read returns 0x00000000.
REQ-038 With LATENCY=0: acceptance in cycle T.
- Required: ready exactly in cycle T+1.
- Required: back-to-back acceptance in cycles T and T+2.
